// File: rtl/midori128_pkg.sv
// Midori128 shared constants: S-box, bit permutations, shuffle, round
// constants, cell/byte layout helpers and FSM encoding.
package midori128_pkg;

  localparam int NUM_FULL_ROUNDS = 19;

  typedef logic [1:0] fsm_t;
  localparam fsm_t S_IDLE  = 2'd0;
  localparam fsm_t S_RUN   = 2'd1;
  localparam fsm_t S_FINAL = 2'd2;
  localparam fsm_t S_DONE  = 2'd3;

  localparam logic [3:0] SB1 [16] = '{
    4'h1, 4'h0, 4'h5, 4'h3, 4'he, 4'h2, 4'hf, 4'h7,
    4'hd, 4'ha, 4'h9, 4'hb, 4'hc, 4'h8, 4'h4, 4'h6
  };

  // Bit k counts from the MSB of the byte.
  localparam logic [2:0] SSB_PERM [4][8] = '{
    '{3'd4, 3'd1, 3'd6, 3'd3, 3'd0, 3'd5, 3'd2, 3'd7},
    '{3'd1, 3'd6, 3'd7, 3'd0, 3'd5, 3'd2, 3'd3, 3'd4},
    '{3'd2, 3'd3, 3'd4, 3'd1, 3'd6, 3'd7, 3'd0, 3'd5},
    '{3'd7, 3'd4, 3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd6}
  };

  localparam logic [3:0] SHUFFLE [16] = '{
    4'd0,  4'd10, 4'd5,  4'd15, 4'd14, 4'd4,  4'd11, 4'd1,
    4'd9,  4'd3,  4'd12, 4'd6,  4'd7,  4'd13, 4'd2,  4'd8
  };

  // Bit i goes into the LSB of cell s_i.
  localparam logic [15:0] ALPHA [0:18] = '{
    16'b1100_1101_1010_1000,
    16'b0000_0011_0001_1110,
    16'b1010_1100_0010_0101,
    16'b1100_1000_0100_0110,
    16'b1111_0010_0000_1000,
    16'b0000_1110_1000_1011,
    16'b0110_0110_0100_0000,
    16'b0011_0011_1101_0000,
    16'b1000_0001_0010_1001,
    16'b0001_1101_0000_0010,
    16'b1110_1001_1000_1110,
    16'b0111_0001_0100_0100,
    16'b0000_1100_1000_1010,
    16'b0101_0011_0001_1111,
    16'b0000_1001_1111_1011,
    16'b1000_0001_0011_1110,
    16'b0010_0100_0011_1000,
    16'b0010_1101_1100_0100,
    16'b0101_0001_0100_0110
  };

  function automatic int cell_byte(input int i);
    return 4 * (i % 4) + i / 4;
  endfunction

  function automatic logic [127:0] to_int(input logic [127:0] p);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*cell_byte(i) +: 8] = p[127-8*i -: 8];
    return r;
  endfunction

  function automatic logic [127:0] to_port(input logic [127:0] r);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 16; i++)
      p[127-8*i -: 8] = r[8*cell_byte(i) +: 8];
    return p;
  endfunction

  function automatic logic [127:0] alpha_vec(input logic [15:0] a);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*cell_byte(i)] = a[i];
    return r;
  endfunction

  function automatic logic [7:0] ssb(input logic [7:0] x, input int idx);
    logic [7:0] y;
    logic [7:0] t;
    logic [7:0] z;
    y = '0;
    z = '0;
    for (int j = 0; j < 8; j++)
      y[7-j] = x[7-int'(SSB_PERM[idx][j])];
    t = {SB1[y[7:4]], SB1[y[3:0]]};
    for (int j = 0; j < 8; j++)
      z[7-int'(SSB_PERM[idx][j])] = t[7-j];
    return z;
  endfunction

endpackage

// File: rtl/midori128_mix_columns.sv
// Midori MixColumn on the internal layout: column c is bytes
// {c, c+4, c+8, c+12}; each output byte is the XOR of the other three.
module midori128_mix_columns (
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = din[8*c      +: 8];
    assign a1 = din[8*(c+4)  +: 8];
    assign a2 = din[8*(c+8)  +: 8];
    assign a3 = din[8*(c+12) +: 8];
    assign dout[8*c      +: 8] = a1 ^ a2 ^ a3;
    assign dout[8*(c+4)  +: 8] = a0 ^ a2 ^ a3;
    assign dout[8*(c+8)  +: 8] = a0 ^ a1 ^ a3;
    assign dout[8*(c+12) +: 8] = a0 ^ a1 ^ a2;
  end
endmodule

// File: rtl/midori128_subcell.sv
// Combinational Midori128 SubCell over the internal byte layout.
// Internal byte j holds a cell whose index mod 4 is j/4.
module midori128_subcell
  import midori128_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar j = 0; j < 16; j++) begin : g_ssb
    assign dout[8*j +: 8] = ssb(din[8*j +: 8], j / 4);
  end
endmodule

// File: rtl/midori128_round_core.sv
// Iterative Midori128 encryption: one full round per clock,
// valid/ready on both sides.
module midori128_round_core
  import midori128_pkg::*;
#(
  parameter int ROUNDS = NUM_FULL_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);
  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  fsm_t         st;
  logic [127:0] state_r;
  logic [127:0] key_r;
  logic [4:0]   rnd;
  logic [127:0] sb_q;
  logic [127:0] shuf_q;
  logic [127:0] mc_q;
  logic [15:0]  rc;
  logic         load;

  assign out_valid  = (st == S_DONE);
  assign busy       = (st == S_RUN) || (st == S_FINAL);
  assign in_ready   = (st == S_IDLE) || (out_valid && out_ready);
  assign load       = in_valid && in_ready;
  assign ciphertext = to_port(state_r);

  midori128_subcell u_sb (
    .din  (state_r),
    .dout (sb_q)
  );

  always_comb begin
    shuf_q = '0;
    for (int i = 0; i < 16; i++)
      shuf_q[8*cell_byte(i) +: 8] =
        sb_q[8*cell_byte(int'(SHUFFLE[i])) +: 8];
  end

  midori128_mix_columns u_mc (
    .din  (shuf_q),
    .dout (mc_q)
  );

  // rnd sits one past LAST after the final round; keep the lookup in range.
  always_comb begin
    rc = '0;
    if (rnd <= LAST) rc = ALPHA[rnd];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= S_IDLE;
      state_r <= '0;
      key_r   <= '0;
      rnd     <= '0;
    end else begin
      unique case (st)
        S_IDLE, S_DONE: begin
          if (load) begin
            state_r <= to_int(plaintext ^ key);
            key_r   <= to_int(key);
            rnd     <= '0;
            st      <= S_RUN;
          end else if (out_valid && out_ready) begin
            st <= S_IDLE;
          end
        end
        S_RUN: begin
          state_r <= mc_q ^ key_r ^ alpha_vec(rc);
          rnd     <= rnd + 5'd1;
          if (rnd == LAST) st <= S_FINAL;
        end
        S_FINAL: begin
          state_r <= sb_q ^ key_r;
          st      <= S_DONE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
